// File: rtl/clz_normalise_pkg.sv
// Shared definitions for the normalisation stage and the pack stage after it.
//   COARSE_STEP : granularity of the first (coarse) shift; the fine shift
//                 covers the remainder 0..COARSE_STEP-1.
//   FLAG_*      : bit positions inside the {zero, underflow} flag vector.
package clz_normalise_pkg;

  localparam int COARSE_STEP = 4;

  localparam int FLAG_UF   = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_W    = 2;

  typedef logic [FLAG_W-1:0] norm_flags_t;

endpackage

// File: rtl/clz_normalise_shl.sv
// Parameterised combinational logical left shifter.
//   din  : value to shift (W bits)
//   amt  : shift amount (SH_W bits)
//   dout : din << amt, truncated to W bits
module clz_normalise_shl #(
  parameter int W    = 16,
  parameter int SH_W = 4
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] amt,
  output logic [W-1:0]    dout
);

  assign dout = din << amt;

endmodule

// File: rtl/clz_normalise.sv
// Two-stage normalisation pipeline after the leading-zero counter.
// Left-shifts the mantissa by min(lz, exp) so its MSB becomes 1 where the
// exponent allows it, and lowers the exponent by the same amount.
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : upstream handshake
//   in_mant, in_exp, in_lz        : mantissa, exponent, leading-zero count
//   in_lz_valid                   : 0 when in_mant is all zeros
//   out_valid/out_ready           : downstream handshake
//   out_mant, out_exp             : normalised mantissa, adjusted exponent
//   out_zero, out_underflow       : input was zero / exponent clamped
module clz_normalise #(
  parameter int MANT_W = 16,
  parameter int EXP_W  = 8,
  parameter int LZ_W   = $clog2(MANT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [LZ_W-1:0]   in_lz,
  input  logic              in_lz_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_underflow
);

  import clz_normalise_pkg::*;

  localparam int CMP_W  = (LZ_W > EXP_W) ? LZ_W : EXP_W;
  localparam int FINE_W = $clog2(COARSE_STEP);

  logic              v1, v2, adv1, adv2;
  logic [CMP_W-1:0]  lz_ext, exp_ext, sh_ext;
  logic [LZ_W-1:0]   sh, sh_coarse;
  logic [EXP_W-1:0]  exp_adj, exp1, exp2;
  logic [MANT_W-1:0] mant_src, mant_coarse, mant1, mant_fine, mant2;
  logic [FINE_W-1:0] fine1;
  norm_flags_t       flags_in, flags1, flags2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // Clamp the shift to the exponent so the biased exponent never wraps;
  // a clamped word leaves the stage only partially normalised.
  always_comb begin
    lz_ext   = CMP_W'(in_lz);
    exp_ext  = CMP_W'(in_exp);
    flags_in = '0;
    sh_ext   = '0;
    exp_adj  = '0;
    mant_src = '0;
    if (!in_lz_valid) begin
      flags_in[FLAG_ZERO] = 1'b1;
    end else begin
      sh_ext            = (lz_ext < exp_ext) ? lz_ext : exp_ext;
      flags_in[FLAG_UF] = (lz_ext > exp_ext);
      mant_src          = in_mant;
      exp_adj           = EXP_W'(exp_ext - sh_ext);
    end
    sh        = LZ_W'(sh_ext);
    sh_coarse = sh & ~LZ_W'(COARSE_STEP - 1);
  end

  clz_normalise_shl #(.W(MANT_W), .SH_W(LZ_W)) u_shl_coarse (
    .din  (mant_src),
    .amt  (sh_coarse),
    .dout (mant_coarse)
  );

  clz_normalise_shl #(.W(MANT_W), .SH_W(FINE_W)) u_shl_fine (
    .din  (mant1),
    .amt  (fine1),
    .dout (mant_fine)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      mant1  <= '0;
      fine1  <= '0;
      exp1   <= '0;
      flags1 <= '0;
      mant2  <= '0;
      exp2   <= '0;
      flags2 <= '0;
    end else begin
      if (adv1) begin
        v1     <= in_valid;
        mant1  <= mant_coarse;
        fine1  <= sh[FINE_W-1:0];
        exp1   <= exp_adj;
        flags1 <= flags_in;
      end
      if (adv2) begin
        v2     <= v1;
        mant2  <= mant_fine;
        exp2   <= exp1;
        flags2 <= flags1;
      end
    end
  end

  // S2 also loads empty slots, so gate the payload to keep idle outputs at 0.
  assign out_valid     = v2;
  assign out_mant      = v2 ? mant2 : '0;
  assign out_exp       = v2 ? exp2 : '0;
  assign out_zero      = v2 & flags2[FLAG_ZERO];
  assign out_underflow = v2 & flags2[FLAG_UF];

endmodule

// File: tb/tb_clz_normalise.sv
module tb_clz_normalise;

  localparam int MANT_W = 16;
  localparam int EXP_W  = 8;
  localparam int LZ_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic [LZ_W-1:0]   in_lz;
  logic              in_lz_valid;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_zero;
  logic              out_underflow;

  clz_normalise #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mant       (in_mant),
    .in_exp        (in_exp),
    .in_lz         (in_lz),
    .in_lz_valid   (in_lz_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mant      (out_mant),
    .out_exp       (out_exp),
    .out_zero      (out_zero),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mant;
    logic [7:0]  exp;
    logic [3:0]  lz;
    logic        lzv;
  } word_t;

  typedef struct {
    logic [15:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uf;
  } res_t;

  word_t pend[$];
  res_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic        prev_stall;
  logic [25:0] prev_out;
  logic        last_acc, last_xfer, last_irdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: shift by min(lz, exp) with plain integer arithmetic.
  function automatic res_t model(input word_t w);
    res_t r;
    int   sh;
    if (!w.lzv) begin
      r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uf = 1'b0;
    end else begin
      sh     = (int'(w.lz) < int'(w.exp)) ? int'(w.lz) : int'(w.exp);
      r.mant = 16'((int'(w.mant) << sh) & 'hFFFF);
      r.exp  = 8'(int'(w.exp) - sh);
      r.zero = 1'b0;
      r.uf   = (int'(w.lz) > int'(w.exp));
    end
    return r;
  endfunction

  function automatic word_t mk_word(input logic [15:0] m, input logic [7:0] e,
                                    input logic [3:0] lz, input logic lzv);
    word_t w;
    w.mant = m; w.exp = e; w.lz = lz; w.lzv = lzv;
    return w;
  endfunction

  function automatic res_t mk_res(input logic [15:0] m, input logic [7:0] e,
                                  input logic z, input logic u);
    res_t r;
    r.mant = m; r.exp = e; r.zero = z; r.uf = u;
    return r;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    int    lz;
    w.lzv = ($urandom_range(0, 7) != 0);
    if (w.lzv) begin
      lz     = $urandom_range(0, 15);
      w.lz   = 4'(lz);
      w.mant = 16'((32'h1 << (15 - lz)) | ($urandom & ((32'h1 << (15 - lz)) - 1)));
    end else begin
      w.lz   = 4'($urandom);
      w.mant = '0;
    end
    w.exp = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
    return w;
  endfunction

  // One clock cycle: drive from pend, sample away from the edge, update the
  // scoreboard after the edge, return at the next falling edge.
  task automatic step(input logic ordy);
    logic        acc, xfer, irdy_exp;
    logic [25:0] outs;
    res_t        r;
    if (pend.size() > 0) begin
      in_valid = 1'b1; in_mant = pend[0].mant; in_exp = pend[0].exp;
      in_lz = pend[0].lz; in_lz_valid = pend[0].lzv;
    end else begin
      in_valid = 1'b0; in_mant = '0; in_exp = '0; in_lz = '0; in_lz_valid = 1'b0;
    end
    out_ready = ordy;
    #1;
    irdy_exp = (sb.size() < 2) || ordy;
    chk("in_ready", 32'(in_ready), 32'(irdy_exp));
    outs = {out_zero, out_underflow, out_exp, out_mant};
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'(outs), 32'(prev_out));
    end
    acc        = in_valid && in_ready;
    xfer       = out_valid && out_ready;
    last_irdy  = in_ready;
    prev_stall = out_valid && !out_ready;
    prev_out   = outs;
    @(posedge clk);
    if (xfer) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        r = sb.pop_front();
        chk("out_mant", 32'(outs[15:0]), 32'(r.mant));
        chk("out_exp", 32'(outs[23:16]), 32'(r.exp));
        chk("out_underflow", 32'(outs[24]), 32'(r.uf));
        chk("out_zero", 32'(outs[25]), 32'(r.zero));
      end
    end
    if (acc) begin
      sb.push_back(model(pend[0]));
      void'(pend.pop_front());
    end
    last_acc  = acc;
    last_xfer = xfer;
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input word_t w, input res_t want);
    pend.push_back(w);
    step(1'b1);
    chk({tag, "_acc"}, 32'(last_acc), 32'd1);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step(1'b1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_mant"}, 32'(out_mant), 32'(want.mant));
    chk({tag, "_exp"}, 32'(out_exp), 32'(want.exp));
    chk({tag, "_zero"}, 32'(out_zero), 32'(want.zero));
    chk({tag, "_uf"}, 32'(out_underflow), 32'(want.uf));
    step(1'b1);
    chk({tag, "_xfer"}, 32'(last_xfer), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen, saw_low, ordy;
    int   stall_left, first_x, last_x, nx;

    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_lz = '0;
    in_lz_valid = 1'b0; out_ready = 1'b0; prev_stall = 1'b0; prev_out = '0;
    last_acc = 1'b0; last_xfer = 1'b0; last_irdy = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bus", 32'({out_zero, out_underflow, out_exp, out_mant}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    directed("basic",    mk_word(16'h0F00, 8'd20, 4'd4, 1'b1),  mk_res(16'hF000, 8'd16, 1'b0, 1'b0));
    directed("zero",     mk_word(16'h0000, 8'd77, 4'd3, 1'b0),  mk_res(16'h0000, 8'd0, 1'b1, 1'b0));
    directed("uf_clamp", mk_word(16'h0001, 8'd3, 4'd15, 1'b1),  mk_res(16'h0008, 8'd0, 1'b0, 1'b1));
    directed("exact",    mk_word(16'h0001, 8'd15, 4'd15, 1'b1), mk_res(16'h8000, 8'd0, 1'b0, 1'b0));
    directed("max_sh",   mk_word(16'h0001, 8'd200, 4'd15, 1'b1), mk_res(16'h8000, 8'd185, 1'b0, 1'b0));
    directed("exp0",     mk_word(16'h0400, 8'd0, 4'd5, 1'b1),   mk_res(16'h0400, 8'd0, 1'b0, 1'b1));
    directed("mix",      mk_word(16'h0100, 8'd100, 4'd7, 1'b1), mk_res(16'h8000, 8'd93, 1'b0, 1'b0));

    // Six back-to-back words, first output held off for four cycles.
    for (int i = 0; i < 6; i++) pend.push_back(rand_word());
    seen = 1'b0; saw_low = 1'b0; stall_left = 0; first_x = -1; last_x = -1; nx = 0;
    for (int c = 0; c < 60 && (pend.size() > 0 || sb.size() > 0); c++) begin
      if (!seen && out_valid) begin
        seen = 1'b1;
        stall_left = 4;
      end
      ordy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      step(ordy);
      if (!last_irdy) saw_low = 1'b1;
      if (last_xfer) begin
        if (first_x < 0) first_x = c;
        last_x = c;
        nx++;
      end
    end
    chk("bp_ready_drop", 32'(saw_low), 32'd1);
    chk("bp_count", 32'(nx), 32'd6);
    chk("bp_rate", 32'(last_x - first_x), 32'd5);
    chk("bp_drained", 32'(pend.size() + sb.size()), 32'd0);

    for (int c = 0; c < 400; c++) begin
      if (pend.size() < 2 && $urandom_range(0, 3) != 0) pend.push_back(rand_word());
      step($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 50 && (pend.size() > 0 || sb.size() > 0); c++) step(1'b1);
    chk("rand_drained", 32'(pend.size() + sb.size()), 32'd0);

    // Fill both stages, then reset mid-cycle.
    for (int i = 0; i < 3; i++) pend.push_back(rand_word());
    for (int c = 0; c < 10 && sb.size() < 2; c++) step(1'b0);
    chk("rst_fill", 32'(sb.size()), 32'd2);
    chk("rst_fill_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_bus", 32'({out_zero, out_underflow, out_exp, out_mant}), 32'd0);
    pend.delete();
    sb.delete();
    in_valid = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step(1'b1);
      chk("no_stale_out", 32'(out_valid), 32'd0);
    end

    directed("after_rst", mk_word(16'h0F00, 8'd20, 4'd4, 1'b1), mk_res(16'hF000, 8'd16, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clz_normalise.md
Name: clz_normalise

Overview:
Pipelined normalisation stage placed directly downstream of the leading-zero counter. It takes a mantissa/exponent pair together with that mantissa's leading-zero count and valid flag. It left-shifts the mantissa so its MSB is 1, and decrements the exponent by the same amount. The result is passed to the rounding/pack stage over a valid/ready handshake, with 2-cycle latency and a throughput of one result per cycle.

Parameters:
MANT_W, 16, mantissa width; must be a power of two, at least 4
EXP_W, 8, unsigned biased exponent width
LZ_W, $clog2(MANT_W), leading-zero count width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word present
in_ready  output  1  stage can accept a word this cycle
in_mant  input  MANT_W  mantissa to normalise
in_exp  input  EXP_W  exponent of in_mant
in_lz  input  LZ_W  leading-zero count of in_mant
in_lz_valid  input  1  0 means in_mant is all zeros
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  normalised mantissa
out_exp  output  EXP_W  adjusted exponent
out_zero  output  1  input was zero
out_underflow  output  1  exponent clamped; result not fully normalised

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately on assertion. While rst is high:
  - both stage valid bits = 0;
  - out_valid, out_mant, out_exp, out_zero, out_underflow = 0;
  - in_ready = 1 after release.
- Datapath registers need not be reset, but outputs must read 0 while out_valid = 0 after reset.
- Accept/transfer rules: a word is accepted when in_valid && in_ready. A result is transferred when out_valid && out_ready.
- Pipeline control:
  - Two register stages, S1 and S2, each with a valid bit v1/v2.
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1. This is a combinational path from out_ready to in_ready; it is the only permitted combinational path through the block.
  - No combinational path from any in_* data/valid signal to any out_* signal.
- Shift amount, computed before S1:
  - sh = min(in_lz, in_exp), compared at width max(LZ_W, EXP_W).
  - uf = (in_lz > in_exp).
  - zero = !in_lz_valid. When zero = 1, force sh = 0, uf = 0, exp = 0, mant = 0.
- S1 (loaded when adv1):
  - mant1 = in_mant << (sh with its 2 LSBs cleared), the coarse shift.
  - fine1 = sh[1:0].
  - exp1 = in_exp - sh. Never negative, by the clamp.
  - zero1, uf1 are registered.
  - v1 <= in_valid.
- S2 (loaded when adv2):
  - out_mant = mant1 << fine1.
  - out_exp = exp1; out_zero = zero1; out_underflow = uf1.
  - v2 <= v1.
- Stall: when adv1 = 0, S1 holds its contents. When adv2 = 0, S2 holds and all outputs remain stable while out_valid = 1.
- Latency: a word accepted at edge N is presented at edge N+2 if there is no backpressure.
- Boundaries:
  - in_lz = MANT_W-1 with in_exp large: shift MANT_W-1, result mant = 1 followed by zeros.
  - in_exp = 0 with nonzero in_lz: no shift; uf = 1; mant passes through unchanged.
  - in_exp = in_lz: full shift, exp = 0, uf = 0.
  - Simultaneous accept and transfer with both stages full: both stages advance, nothing is lost or duplicated.
  - rst asserted mid-stream: in-flight words are discarded; no output after release until new words are accepted.
- Ordering: strictly FIFO; there is no reordering or bubble squashing beyond the natural advance of each stage.

Decomposition:
- Shared package holds:
  - flag bit positions for {zero, underflow}, reused by the pack stage;
  - the localparam COARSE_STEP = 4.
- One natural sub-module: clz_normalise_shl, a parameterised combinational left shifter. It is instantiated twice: the coarse shifter (amount a multiple of 4) and the fine shifter (amount 0-3).
- Control (v1/v2, adv logic) stays inline.

Test Plan:
- Basic shift: mant=0x0F00, exp=20, lz=4, lz_valid=1, out_ready=1 -> after 2 cycles mant=0xF000, exp=16, zero=0, underflow=0.
- Zero input: mant=0x0000, lz_valid=0, exp=77 -> mant=0x0000, exp=0, zero=1, underflow=0.
- Underflow clamp: mant=0x0001, exp=3, lz=15 -> mant=0x0008, exp=0, underflow=1.
- Exact fit: mant=0x0001, exp=15, lz=15 -> mant=0x8000, exp=0, underflow=0.
- Backpressure: stream 6 words back-to-back while out_ready is held low for 4 cycles after the first output:
  - in_ready drops after the pipeline holds 2 words;
  - outputs stay stable while stalled;
  - all 6 arrive in order, none dropped or duplicated;
  - steady state is one result per cycle.
- Reset mid-operation: assert rst with v1 = v2 = 1 -> out_valid = 0 immediately (asynchronous). After release, in_ready = 1, and no stale result appears.
